// File: rtl/data_memory_bytelane.sv
// ---------------------------------------------------------------------------
// data_memory_bytelane
//
// Byte-addressable 32-bit data memory for the RV32 load/store path.
// Supports LB/LH/LW/LBU/LHU loads and SB/SH/SW stores with per-byte write
// enables, reports misaligned and illegal-funct3 requests as faults, and
// returns one response per accepted request after READ_LATENCY cycles.
// After reset an optional clear sequence zeroes every word before the
// first request is accepted.
//
// Parameters
//   ADDR_WIDTH      byte-address width (4..16), NUM_WORDS = 2**(ADDR_WIDTH-2)
//   READ_LATENCY    accept-to-response latency in cycles (1..4)
//   CLEAR_ON_RESET  1 = zero the array after reset, 0 = skip the clear
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_funct3   RV32 funct3 (access width and signedness)
//   req_wdata    store data, right-aligned
//   rsp_valid    one-cycle response pulse
//   rsp_we       response belongs to a store
//   rsp_rdata    extended load data, 0 for stores and faults
//   rsp_fault    request was misaligned or had an illegal funct3
// ---------------------------------------------------------------------------
module data_memory_bytelane #(
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault
);

  localparam int WORD_W    = ADDR_WIDTH - 2;
  localparam int NUM_WORDS = 1 << WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   clr_idx_q;

  logic [31:0]         mem [NUM_WORDS];

  logic                accept;
  logic [WORD_W-1:0]   word;
  logic [1:0]          lane;
  logic                fault;
  logic [3:0]          byte_en;
  logic [31:0]         st_data;
  logic [31:0]         rd_word;
  logic [31:0]         rd_shift;
  logic [31:0]         ld_data;

  // Response pipeline: stage 0 is loaded on the accept edge, the last stage
  // drives the outputs, so the response appears READ_LATENCY-1 edges later.
  logic [READ_LATENCY-1:0] v_q;
  logic [READ_LATENCY-1:0] we_q;
  logic [READ_LATENCY-1:0] fault_q;
  logic [31:0]             data_q [READ_LATENCY];

  assign req_ready = rst_n && (state_q == ST_READY);
  assign accept    = req_valid && req_ready;
  assign word      = req_addr[ADDR_WIDTH-1:2];
  assign lane      = req_addr[1:0];

  // -------------------------------------------------------------------------
  // Clear sequencer FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_idx_q <= clr_idx_q + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_idx_q == LAST_WORD) begin
      state_d = ST_READY;
    end
  end

  // -------------------------------------------------------------------------
  // Request decode: fault detection, store lane enables, load extraction
  // -------------------------------------------------------------------------
  always_comb begin
    fault   = 1'b0;
    byte_en = 4'b0000;
    st_data = 32'h0;

    // Width-dependent misalignment; funct3[1:0] encodes byte/half/word.
    if (req_funct3[1:0] == 2'd1 && lane[0]) fault = 1'b1;
    if (req_funct3[1:0] == 2'd2 && lane != 2'd0) fault = 1'b1;
    if (req_we) begin
      if (req_funct3 > 3'd2) fault = 1'b1;
    end else begin
      if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) fault = 1'b1;
    end

    // Store data is replicated across lanes so the enables alone select
    // which bytes change.
    unique case (req_funct3[1:0])
      2'd0: begin
        byte_en = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        byte_en = 4'b0011 << lane;
        st_data = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        byte_en = 4'b1111;
        st_data = req_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  assign rd_word  = mem[word];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    if (!req_we && !fault) begin
      unique case (req_funct3)
        3'd0:    ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
        3'd1:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        3'd2:    ld_data = rd_word;
        3'd4:    ld_data = {24'h0, rd_shift[7:0]};
        3'd5:    ld_data = {16'h0, rd_shift[15:0]};
        default: ld_data = 32'h0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset branch; contents change only through the
  // clear sequencer or stores, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_idx_q] <= 32'h0;
      end else if (accept && req_we && !fault) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            mem[word][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      we_q    <= '0;
      fault_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      v_q[0]     <= accept;
      we_q[0]    <= accept && req_we;
      fault_q[0] <= accept && fault;
      data_q[0]  <= accept ? ld_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i]     <= v_q[i-1];
        we_q[i]    <= we_q[i-1];
        fault_q[i] <= fault_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign rsp_valid = v_q[READ_LATENCY-1];
  assign rsp_we    = we_q[READ_LATENCY-1];
  assign rsp_fault = fault_q[READ_LATENCY-1];
  assign rsp_rdata = data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_bytelane.sv
// ---------------------------------------------------------------------------
// tb_data_memory_bytelane
//
// Self-checking bench for data_memory_bytelane (ADDR_WIDTH=6,
// READ_LATENCY=2, CLEAR_ON_RESET=1). A byte-array reference model with a
// queue of expected responses is stepped on every rising edge; all outputs
// are compared on every falling edge. Directed scenarios add checks against
// literal values, then a randomized phase exercises mixed traffic and resets.
// ---------------------------------------------------------------------------
module tb_data_memory_bytelane;

  localparam int AW = 6;
  localparam int RL = 2;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_we;
  logic [31:0]   rsp_rdata;
  logic          rsp_fault;

  data_memory_bytelane #(
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------- reference model -------------------------
  typedef struct {
    int          due;
    logic        we;
    logic        fault;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] m_mem [64];
  bit         m_ready  = 1'b0;
  int         m_clr    = 0;
  int         edge_cnt = 0;

  // Applies the inputs sampled at the current rising edge to the model.
  task automatic model_edge();
    int          a;
    int          nb;
    logic        flt;
    logic [31:0] v;
    rsp_t        r;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_clr   = 0;
      exp_q.delete();
    end else if (!m_ready) begin
      for (int b = 0; b < 4; b++) m_mem[m_clr*4 + b] = 8'h00;
      m_clr++;
      if (m_clr == NW) m_ready = 1'b1;
    end else if (req_valid) begin
      a   = int'(req_addr);
      nb  = 1 << req_funct3[1:0];
      flt = req_we ? (req_funct3 > 3'd2)
                   : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
      if (nb == 2 && (a % 2) != 0) flt = 1'b1;
      if (nb == 4 && (a % 4) != 0) flt = 1'b1;
      v = 32'h0;
      if (!flt) begin
        if (req_we) begin
          for (int b = 0; b < nb; b++) m_mem[a + b] = req_wdata[8*b +: 8];
        end else begin
          for (int b = 0; b < nb; b++) v[8*b +: 8] = m_mem[a + b];
          if (!req_funct3[2] && nb < 4 && v[8*nb - 1]) begin
            for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
          end
        end
      end
      r.due   = edge_cnt + RL - 1;
      r.we    = req_we;
      r.fault = flt;
      r.rdata = v;
      exp_q.push_back(r);
    end
  endtask

  task automatic check_outputs();
    logic        ev  = 1'b0;
    logic        ew  = 1'b0;
    logic        ef  = 1'b0;
    logic [31:0] ed  = 32'h0;
    rsp_t        r;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      r  = exp_q.pop_front();
      ev = 1'b1;
      ew = r.we;
      ef = r.fault;
      ed = r.rdata;
    end
    check("req_ready", req_ready, rst_n && m_ready);
    check("rsp_valid", rsp_valid, ev);
    check("rsp_we",    rsp_we,    ew);
    check("rsp_fault", rsp_fault, ef);
    check("rsp_rdata", rsp_rdata, ed);
  endtask

  // Drives one cycle of inputs (from the falling edge), advances the model at
  // the rising edge and checks every output at the following falling edge.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk);
    edge_cnt++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 3'd0, 32'h0);
  endtask

  task automatic store(input logic [AW-1:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    cycle(1'b1, 1'b1, addr, f3, wd);
  endtask

  // Issues a load, waits out the latency and checks the response directly.
  task automatic load_expect(input string tag, input logic [AW-1:0] addr, input logic [2:0] f3,
                             input logic [31:0] exp_data, input logic exp_fault);
    cycle(1'b1, 1'b0, addr, f3, 32'h0);
    idle();
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_data"},  rsp_rdata, exp_data);
    check({tag, "_fault"}, rsp_fault, exp_fault);
  endtask

  // Releases reset and counts edges until req_ready rises (bounded).
  task automatic release_and_wait(input string tag);
    int n = 0;
    rst_n = 1'b1;
    while (!req_ready && n < 100) begin
      idle();
      n++;
    end
    check(tag, n, NW);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [2:0]    f3;
    logic [2:0]    legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    // 1. Reset and clear
    rst_n = 1'b0;
    repeat (3) idle();
    release_and_wait("clear_len");
    load_expect("clr_lw00", 6'h00, 3'd2, 32'h0000_0000, 1'b0);
    load_expect("clr_lw3c", 6'h3C, 3'd2, 32'h0000_0000, 1'b0);

    // 2. Byte lanes
    store(6'h08, 3'd2, 32'h1122_3344);
    store(6'h09, 3'd0, 32'h0000_00AB);
    store(6'h0A, 3'd1, 32'h0000_CDEF);
    load_expect("lanes", 6'h08, 3'd2, 32'hCDEF_AB44, 1'b0);

    // 3. Extension
    store(6'h10, 3'd2, 32'h80FF_7F01);
    load_expect("lb13",  6'h13, 3'd0, 32'hFFFF_FF80, 1'b0);
    load_expect("lbu13", 6'h13, 3'd4, 32'h0000_0080, 1'b0);
    load_expect("lh10",  6'h10, 3'd1, 32'h0000_7F01, 1'b0);
    load_expect("lhu12", 6'h12, 3'd5, 32'h0000_80FF, 1'b0);

    // 4. Faults
    store(6'h20, 3'd2, 32'h5566_7788);
    store(6'h21, 3'd2, 32'hFFFF_FFFF);
    idle();
    check("sw_mis_fault", rsp_fault, 1'b1);
    check("sw_mis_we",    rsp_we,    1'b1);
    load_expect("sw_mis_keep", 6'h20, 3'd2, 32'h5566_7788, 1'b0);
    load_expect("lh_mis",      6'h23, 3'd1, 32'h0000_0000, 1'b1);
    load_expect("ld_f3_3",     6'h20, 3'd3, 32'h0000_0000, 1'b1);

    // 5. Back-to-back store then load
    store(6'h04, 3'd2, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 6'h04, 3'd2, 32'h0);
    check("b2b_st_valid", rsp_valid, 1'b1);
    check("b2b_st_we",    rsp_we,    1'b1);
    idle();
    check("b2b_ld_valid", rsp_valid, 1'b1);
    check("b2b_ld_we",    rsp_we,    1'b0);
    check("b2b_ld_data",  rsp_rdata, 32'hDEAD_BEEF);
    idle();
    check("b2b_idle",     rsp_valid, 1'b0);

    // 6. Reset mid-flight
    cycle(1'b1, 1'b0, 6'h04, 3'd2, 32'h0);
    rst_n = 1'b0;
    idle();
    check("rst_drop_valid", rsp_valid, 1'b0);
    idle();
    check("rst_drop_valid2", rsp_valid, 1'b0);
    release_and_wait("reclear_len");
    load_expect("reclear_lw04", 6'h04, 3'd2, 32'h0000_0000, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
      end
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) f3 = legal_f3[$urandom_range(0, 4)];
      a  = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0]   = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      cycle(v, we, a, f3, $urandom());
    end
    repeat (RL + 1) idle();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
